stopwatch_time_counter: RTL and testbench

// - Receiving end of the stopwatch tick clock. Samples the divided 100 Hz tick from the clock divider in
//   the system clk domain and advances a BCD time-of-count MM:SS.CC (centiseconds).
// - Provides lap-freeze and clear controls and a sticky overflow flag.
// - Its outputs feed the 7-segment display driver.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/bcd_digit_counter.sv | 40 ++++
 rtl/stopwatch_time_counter.sv | 152 +++++++++++++++
 tb/tb_stopwatch_time_counter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time counter: digit geometry,
// digit positions within the display word, and the lap FSM encoding.
package stopwatch_pkg;

    localparam int BCD_W  = 4;
    localparam int DIGITS = 6;

    localparam int C1  = 0;
    localparam int C10 = 1;
    localparam int S1  = 2;
    localparam int S10 = 3;
    localparam int M1  = 4;
    localparam int M10 = 5;

    typedef enum logic {
        RUN = 1'b0,
        LAP = 1'b1
    } lap_state_e;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MOD-1 with synchronous clear; carry fires on the
// enabled step that wraps the digit back to zero.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic [BCD_W-1:0] q_nxt,
    output logic             carry
);

    localparam logic [BCD_W-1:0] TERM = BCD_W'(MOD - 1);

    assign carry = en && (q == TERM);

    always_comb begin
        // NOTE: default assignment first so every path drives q_nxt and no latch is inferred.
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (en) begin
            q_nxt = (q == TERM) ? '0 : q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignment for sequential state avoids simulation races between flops.
        if (!rst) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Synchronizes the divided 100 Hz tick into clk, counts BCD MM:SS.CC, and
// drives a registered display word with lap-freeze, clear and sticky overflow.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_MOD     = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_clk,
    input  logic                    clear_btn,
    input  logic                    lap_btn,
    output logic [DIGITS*BCD_W-1:0] digits,
    output logic                    lap_active,
    output logic                    overflow,
    output logic                    tick_pulse
);

    localparam logic [BCD_W-1:0] MIN_TENS = BCD_W'((MIN_MOD - 1) / 10);
    localparam logic [BCD_W-1:0] MIN_ONES = BCD_W'((MIN_MOD - 1) % 10);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_d;
    logic                   clear_hist;
    logic                   lap_hist;

    logic tick_rise;
    logic clear_rel;
    logic lap_rel;
    logic tick_acc;
    logic min_wrap;

    logic [BCD_W-1:0] q     [DIGITS];
    logic [BCD_W-1:0] q_nxt [DIGITS];
    logic [M1:C1]     carry;
    logic             m10_carry_unused;

    logic [DIGITS*BCD_W-1:0] live_nxt;
    logic [DIGITS*BCD_W-1:0] lap_q;
    logic [DIGITS*BCD_W-1:0] lap_nxt;

    lap_state_e state_q;
    lap_state_e state_nxt;
    logic       capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            tick_d     <= 1'b0;
            clear_hist <= 1'b0;
            lap_hist   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_clk};
            tick_d     <= sync_q[SYNC_STAGES-1];
            clear_hist <= clear_btn;
            lap_hist   <= lap_btn;
        end
    end

    assign tick_rise = sync_q[SYNC_STAGES-1] & ~tick_d;
    assign clear_rel = clear_hist & ~clear_btn;
    assign lap_rel   = lap_hist & ~lap_btn;
    // A tick landing in the same cycle as a clear is dropped, not counted.
    assign tick_acc  = tick_rise & ~clear_rel;

    bcd_digit_counter #(.MOD(10)) u_c1 (
        .clk(clk), .rst(rst), .en(tick_acc), .clr(clear_rel),
        .q(q[C1]), .q_nxt(q_nxt[C1]), .carry(carry[C1])
    );
    bcd_digit_counter #(.MOD(10)) u_c10 (
        .clk(clk), .rst(rst), .en(carry[C1]), .clr(clear_rel),
        .q(q[C10]), .q_nxt(q_nxt[C10]), .carry(carry[C10])
    );
    bcd_digit_counter #(.MOD(10)) u_s1 (
        .clk(clk), .rst(rst), .en(carry[C10]), .clr(clear_rel),
        .q(q[S1]), .q_nxt(q_nxt[S1]), .carry(carry[S1])
    );
    bcd_digit_counter #(.MOD(6)) u_s10 (
        .clk(clk), .rst(rst), .en(carry[S1]), .clr(clear_rel),
        .q(q[S10]), .q_nxt(q_nxt[S10]), .carry(carry[S10])
    );

    // Minutes wrap on the MIN_MOD terminal value rather than their own BCD limit.
    assign min_wrap = carry[S10] && (q[M10] == MIN_TENS) && (q[M1] == MIN_ONES);

    bcd_digit_counter #(.MOD(10)) u_m1 (
        .clk(clk), .rst(rst), .en(carry[S10]), .clr(clear_rel | min_wrap),
        .q(q[M1]), .q_nxt(q_nxt[M1]), .carry(carry[M1])
    );
    bcd_digit_counter #(.MOD(10)) u_m10 (
        .clk(clk), .rst(rst), .en(carry[M1]), .clr(clear_rel | min_wrap),
        .q(q[M10]), .q_nxt(q_nxt[M10]), .carry(m10_carry_unused)
    );

    always_comb begin
        live_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            live_nxt[i*BCD_W +: BCD_W] = q_nxt[i];
        end
    end

    always_comb begin
        state_nxt = state_q;
        capture   = 1'b0;
        if (clear_rel) begin
            state_nxt = RUN;
        end else if (lap_rel) begin
            case (state_q)
                RUN: begin
                    state_nxt = LAP;
                    capture   = 1'b1;
                end
                LAP:     state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        lap_nxt = lap_q;
        if (clear_rel) begin
            lap_nxt = '0;
        end else if (capture) begin
            lap_nxt = live_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            lap_q      <= '0;
            digits     <= '0;
            overflow   <= 1'b0;
            tick_pulse <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            lap_q      <= lap_nxt;
            // Select on the next state so the display moves on the same edge as the count.
            digits     <= (state_nxt == LAP) ? lap_nxt : live_nxt;
            tick_pulse <= tick_acc;
            if (clear_rel) begin
                overflow <= 1'b0;
            end else if (min_wrap) begin
                overflow <= 1'b1;
            end
        end
    end

    assign lap_active = (state_q == LAP);

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench: a 60-minute counter and a 1-minute twin share all stimulus
// so the full-scale wrap can be reached in a short run.
module tb_stopwatch_time_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_clk = 1'b0;
    logic        clear_btn = 1'b0;
    logic        lap_btn = 1'b0;
    logic [23:0] digits, digits_w;
    logic        lap_active, lap_active_w;
    logic        overflow, overflow_w;
    logic        tick_pulse, tick_pulse_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stopwatch_time_counter #(.SYNC_STAGES(2), .MIN_MOD(60)) dut (
        .clk(clk), .rst(rst), .tick_clk(tick_clk), .clear_btn(clear_btn),
        .lap_btn(lap_btn), .digits(digits), .lap_active(lap_active),
        .overflow(overflow), .tick_pulse(tick_pulse)
    );

    stopwatch_time_counter #(.SYNC_STAGES(2), .MIN_MOD(1)) dut_w (
        .clk(clk), .rst(rst), .tick_clk(tick_clk), .clear_btn(clear_btn),
        .lap_btn(lap_btn), .digits(digits_w), .lap_active(lap_active_w),
        .overflow(overflow_w), .tick_pulse(tick_pulse_w)
    );

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_clk = 1'b1;
            @(negedge clk) tick_clk = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic press_clear();
        @(negedge clk) clear_btn = 1'b1;
        @(negedge clk) clear_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_lap();
        @(negedge clk) lap_btn = 1'b1;
        @(negedge clk) lap_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (digits !== 24'h000000 || lap_active !== 1'b0 || overflow !== 1'b0 || tick_pulse !== 1'b0) begin
            $display("FAIL reset_state: digits=%h lap=%b ovf=%b pulse=%b, want 000000 0 0 0",
                     digits, lap_active, overflow, tick_pulse);
            fails++;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tick_latency();
        @(negedge clk) tick_clk = 1'b1;
        @(negedge clk) tick_clk = 1'b0;
        tests++;
        if (tick_pulse !== 1'b0 || digits !== 24'h000000) begin
            $display("FAIL latency_clk1: digits=%h pulse=%b, want 000000 0", digits, tick_pulse);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (tick_pulse !== 1'b0 || digits !== 24'h000000) begin
            $display("FAIL latency_clk2: digits=%h pulse=%b, want 000000 0", digits, tick_pulse);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (tick_pulse !== 1'b1 || digits !== 24'h000001) begin
            $display("FAIL latency_clk3: digits=%h pulse=%b, want 000001 1", digits, tick_pulse);
            fails++;
        end
        @(negedge clk);
        tests++;
        if (tick_pulse !== 1'b0 || digits !== 24'h000001) begin
            $display("FAIL pulse_width: digits=%h pulse=%b, want 000001 0", digits, tick_pulse);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        run_ticks(122);
        settle();
        tests++;
        if (digits !== 24'h000123) begin
            $display("FAIL count_123: digits=%h, want 000123", digits);
            fails++;
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        tests++;
        if (digits !== 24'h000000 || overflow !== 1'b0 || lap_active !== 1'b0 ||
            digits_w !== 24'h000000) begin
            $display("FAIL async_reset: digits=%h ovf=%b lap=%b twin=%h, want 000000 0 0 000000",
                     digits, overflow, lap_active, digits_w);
            fails++;
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_minute_carry();
        run_ticks(5999);
        settle();
        tests++;
        if (digits !== 24'h005999 || digits_w !== 24'h005999 || overflow_w !== 1'b0) begin
            $display("FAIL at_005999: digits=%h twin=%h twin_ovf=%b, want 005999 005999 0",
                     digits, digits_w, overflow_w);
            fails++;
        end
        run_ticks(1);
        settle();
        tests++;
        if (digits !== 24'h010000 || overflow !== 1'b0) begin
            $display("FAIL minute_carry: digits=%h ovf=%b, want 010000 0", digits, overflow);
            fails++;
        end
        tests++;
        if (digits_w !== 24'h000000 || overflow_w !== 1'b1) begin
            $display("FAIL max_wrap: digits=%h ovf=%b, want 000000 1", digits_w, overflow_w);
            fails++;
        end
        run_ticks(1);
        settle();
        tests++;
        if (digits_w !== 24'h000001 || overflow_w !== 1'b1 || digits !== 24'h010001) begin
            $display("FAIL ovf_sticky: twin=%h twin_ovf=%b digits=%h, want 000001 1 010001",
                     digits_w, overflow_w, digits);
            fails++;
        end
        press_clear();
        tests++;
        if (digits !== 24'h000000 || digits_w !== 24'h000000 || overflow_w !== 1'b0) begin
            $display("FAIL clear_ovf: digits=%h twin=%h twin_ovf=%b, want 000000 000000 0",
                     digits, digits_w, overflow_w);
            fails++;
        end
    endtask

    task automatic test_lap();
        run_ticks(1000);
        settle();
        press_lap();
        tests++;
        if (digits !== 24'h001000 || lap_active !== 1'b1) begin
            $display("FAIL lap_capture: digits=%h lap=%b, want 001000 1", digits, lap_active);
            fails++;
        end
        run_ticks(75);
        settle();
        tests++;
        if (digits !== 24'h001000) begin
            $display("FAIL lap_hold_mid: digits=%h, want 001000", digits);
            fails++;
        end
        run_ticks(75);
        settle();
        tests++;
        if (digits !== 24'h001000 || lap_active !== 1'b1) begin
            $display("FAIL lap_hold_end: digits=%h lap=%b, want 001000 1", digits, lap_active);
            fails++;
        end
        press_lap();
        tests++;
        if (digits !== 24'h001150 || lap_active !== 1'b0) begin
            $display("FAIL lap_resume: digits=%h lap=%b, want 001150 0", digits, lap_active);
            fails++;
        end
    endtask

    task automatic test_clear_coincident();
        press_clear();
        run_ticks(2109);
        settle();
        tests++;
        if (digits !== 24'h002109) begin
            $display("FAIL at_002109: digits=%h, want 002109", digits);
            fails++;
        end
        @(negedge clk) tick_clk = 1'b1;
        @(negedge clk) begin
            tick_clk  = 1'b0;
            clear_btn = 1'b1;
        end
        @(negedge clk) clear_btn = 1'b0;
        @(negedge clk);
        tests++;
        if (digits !== 24'h000000 || overflow !== 1'b0 || tick_pulse !== 1'b0) begin
            $display("FAIL clear_vs_tick: digits=%h ovf=%b pulse=%b, want 000000 0 0",
                     digits, overflow, tick_pulse);
            fails++;
        end
        settle();
        run_ticks(1);
        settle();
        tests++;
        if (digits !== 24'h000001) begin
            $display("FAIL after_clear_tick: digits=%h, want 000001", digits);
            fails++;
        end
    endtask

    task automatic test_button_hold();
        @(negedge clk) lap_btn = 1'b1;
        run_ticks(500);
        settle();
        tests++;
        if (digits !== 24'h000501 || lap_active !== 1'b0) begin
            $display("FAIL hold_no_action: digits=%h lap=%b, want 000501 0", digits, lap_active);
            fails++;
        end
        @(negedge clk) lap_btn = 1'b0;
        @(negedge clk);
        tests++;
        if (digits !== 24'h000501 || lap_active !== 1'b1) begin
            $display("FAIL hold_release: digits=%h lap=%b, want 000501 1", digits, lap_active);
            fails++;
        end
        run_ticks(5);
        settle();
        tests++;
        if (digits !== 24'h000501 || lap_active !== 1'b1) begin
            $display("FAIL hold_single_action: digits=%h lap=%b, want 000501 1", digits, lap_active);
            fails++;
        end
        press_lap();
        tests++;
        if (digits !== 24'h000506 || lap_active !== 1'b0) begin
            $display("FAIL hold_exit_lap: digits=%h lap=%b, want 000506 0", digits, lap_active);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_tick_latency();
        test_reset_mid();
        test_minute_carry();
        test_lap();
        test_clear_coincident();
        test_button_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
